// File: rtl/id_branch_predecode.sv
`default_nettype none
// ============================================================================
// Module   : id_branch_predecode
// Brief    : Decode-side front end. Tracks the PC, classifies 16/32-bit
//            instructions, statically predicts jumps and backward branches
//            (combinational redirect to fetch), squashes the stale fetch slot
//            after every redirect, and registers the ID/EX boundary.
// Revision : 1.0 - initial release
// ============================================================================
module id_branch_predecode #(
    parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_f_i,
    input  logic        enable_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] redirection_d_o,
    output logic        taken_d_o,
    output logic        is_compress_d_o,
    output logic        valid_d_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic        pred_taken_d_o
);

    localparam logic [1:0]  S_WARMUP = 2'd0;
    localparam logic [1:0]  S_RUN    = 2'd1;
    localparam logic [1:0]  S_SQUASH = 2'd2;
    localparam logic [1:0]  c_WARMUP_LAST = 2'd2;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_pc;

    logic        w_is_run;
    logic        w_is_c;
    logic        w_predict;
    logic [31:0] w_imm;
    logic [31:0] w_target;
    logic [31:0] w_seq_pc;
    logic        w_taken;
    logic [2:0]  w_cf3;

    assign w_is_run  = (r_state == S_RUN);
    assign w_is_c    = (instruction_f_i[1:0] != 2'b11);
    assign w_cf3     = instruction_f_i[15:13];
    assign w_target  = r_pc + w_imm;
    assign w_seq_pc  = r_pc + (w_is_c ? 32'd2 : 32'd4);
    // Reset gates the pulse so fetch never sees a redirect out of a resetting stage.
    assign w_taken   = ~reset & enable_i & (flush_i | (w_is_run & w_predict));

    assign is_compress_d_o = w_is_c;
    assign taken_d_o       = w_taken;
    assign redirection_d_o = flush_i ? flush_pc_i : w_target;

    // Static predictor: unconditional jumps always, conditional branches only backward.
    always_comb begin
        w_predict = 1'b0;
        w_imm     = 32'd0;
        if (!w_is_c) begin
            if (instruction_f_i[6:0] == c_OP_JAL) begin
                w_predict = 1'b1;
                w_imm = {{12{instruction_f_i[31]}}, instruction_f_i[19:12],
                         instruction_f_i[20], instruction_f_i[30:21], 1'b0};
            end else if (instruction_f_i[6:0] == c_OP_BRANCH) begin
                w_predict = instruction_f_i[31];
                w_imm = {{20{instruction_f_i[31]}}, instruction_f_i[7],
                         instruction_f_i[30:25], instruction_f_i[11:8], 1'b0};
            end
        end else if (instruction_f_i[1:0] == 2'b01) begin
            if (w_cf3 == 3'b101 || w_cf3 == 3'b001) begin
                // C.J / C.JAL
                w_predict = 1'b1;
                w_imm = {{21{instruction_f_i[12]}}, instruction_f_i[8],
                         instruction_f_i[10:9], instruction_f_i[6], instruction_f_i[7],
                         instruction_f_i[2], instruction_f_i[11], instruction_f_i[5:3], 1'b0};
            end else if (w_cf3 == 3'b110 || w_cf3 == 3'b111) begin
                // C.BEQZ / C.BNEZ
                w_predict = instruction_f_i[12];
                w_imm = {{24{instruction_f_i[12]}}, instruction_f_i[6:5],
                         instruction_f_i[2], instruction_f_i[11:10],
                         instruction_f_i[4:3], 1'b0};
            end
        end
    end

    // Control state, PC and ID/EX capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_WARMUP;
            r_cnt          <= 2'd0;
            r_pc           <= BOOT_PC;
            valid_d_o      <= 1'b0;
            instr_d_o      <= c_NOP;
            pc_d_o         <= BOOT_PC;
            pred_taken_d_o <= 1'b0;
        end else begin
            case (r_state)
                S_WARMUP: begin
                    // Warmup counts every cycle, stalled or not; a flush aborts it.
                    if (enable_i && flush_i)
                        r_state <= S_SQUASH;
                    else if (r_cnt == c_WARMUP_LAST)
                        r_state <= S_RUN;
                    else
                        r_cnt <= r_cnt + 2'd1;
                end
                S_RUN: begin
                    if (w_taken)
                        r_state <= S_SQUASH;
                end
                S_SQUASH: begin
                    if (enable_i)
                        r_state <= flush_i ? S_SQUASH : S_RUN;
                end
                default: r_state <= S_WARMUP;
            endcase

            if (enable_i) begin
                if (flush_i)
                    r_pc <= flush_pc_i;
                else if (w_is_run && w_predict)
                    r_pc <= w_target;
                else if (w_is_run)
                    r_pc <= w_seq_pc;

                valid_d_o      <= w_is_run & ~flush_i;
                instr_d_o      <= w_is_c ? {16'h0000, instruction_f_i[15:0]} : instruction_f_i;
                pc_d_o         <= r_pc;
                pred_taken_d_o <= w_is_run & w_predict & ~flush_i;
            end
        end
    end

endmodule
`default_nettype wire
